decimator: RTL and testbench
============================

DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 SHALL have parameter TAPS, default 64; FIR length, power of two.
REQ-002 SHALL have parameter DECIM, default 16; input samples per output sample.
REQ-003 SHALL have parameter COEFF_FILE, default "decim_coeffs.mem"; init file for the TAPS x 18-bit signed coefficient ROM.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port sample_in  input  16  signed 16x-rate input sample.
REQ-007 SHALL have port sample_in_valid  input  1  one-cycle strobe qualifying sample_in; nominal spacing 142 cycles.
REQ-008 SHALL have port sample_out  output  16  signed base-rate output, held between updates.
REQ-009 SHALL have port sample_out_valid  output  1  one-cycle pulse when sample_out updates.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when an input sample is dropped.

Function
REQ-011 SHALL store accepted samples in a TAPS-entry circular history buffer; write pointer advances by 1 per accepted sample, wrapping TAPS-1 -> 0.
REQ-012 SHALL keep phase counter 0..DECIM-1, incremented per accepted sample, wrapping DECIM-1 -> 0; the sample that wraps it is the trigger.
REQ-013 SHALL keep fill counter 0..TAPS, saturating at TAPS; history entries not yet written since reset contribute 0 to the sum.
REQ-014 SHALL use FSM states IDLE, PRIME, MAC, SAT; IDLE -> PRIME on trigger write; PRIME 2 cycles (ROM/buffer latency); MAC TAPS cycles; SAT 1 cycle; SAT -> IDLE.
REQ-015 SHALL compute acc = sum over k=0..TAPS-1 of coeff[k] * x[n-k], x[n] = trigger sample, coeff Q1.17 signed 18-bit, acc signed 48-bit, no intermediate truncation.
REQ-016 SHALL form result = acc >>> 17 (arithmetic, truncation toward -inf), saturated to 16'h7FFF / 16'h8000.
REQ-017 SHALL register result onto sample_out and pulse sample_out_valid exactly TAPS+4 cycles (68 at default) after the trigger sample_in_valid cycle.
REQ-018 SHALL, on sample_in_valid outside IDLE, latch the sample in a one-entry holding register and commit it to the buffer in the cycle after SAT (counting toward phase as if accepted then).
REQ-019 SHALL, on sample_in_valid while the holding register is occupied, drop the new sample, pulse overrun, and leave buffer, phase and holding register unchanged.
REQ-020 SHALL, when a held sample is committed and is itself a trigger, enter PRIME in that commit cycle (output latency then measured from the commit cycle).
REQ-021 SHALL hold sample_out, sample_out_valid=0, overrun=0 in all cycles not named above.
REQ-022 SHALL not modify the history buffer contents read by an in-progress MAC (reads use snapshot of write pointer at trigger).

Reset
REQ-023 SHALL, on rst assertion (asynchronously, any state including mid-MAC), force sample_out=0, sample_out_valid=0, overrun=0, FSM=IDLE, phase=0, fill=0, write pointer=0, accumulator=0, holding register empty.
REQ-024 SHALL not require buffer RAM contents to be cleared; REQ-013 masking guarantees zero contribution of stale entries.
REQ-025 SHALL accept sample_in_valid on the first clock edge after rst deasserts.

Verification
REQ-026 SHALL cover DC: all coeffs 2048 (1/64), 64+ samples of 1000 every 142 cycles -> every sample_out after fill = 1000; first output (16 samples filled) = 250.
REQ-027 SHALL cover impulse: coeff[k]=k*256, input 16384 once then zeros -> successive outputs 0, 512, 1024, 1536 (k=0,16,32,48 at 32768 scale) matching REQ-015/016 bit-exactly against a model.
REQ-028 SHALL cover saturation: all coeffs 131071, input 32767 x64 -> sample_out=16'h7FFF; input -32768 x64 -> 16'h8000.
REQ-029 SHALL cover latency/holding: valid spacing 40 cycles -> output pulse at trigger+68, held sample committed after SAT, no overrun; spacing 20 cycles -> overrun pulse on the second in-MAC sample, that sample absent from model.
REQ-030 SHALL cover reset mid-MAC: rst asserted 30 cycles after trigger -> outputs 0 immediately (before next clk edge), no sample_out_valid for that computation, next output equals fresh-reset model.

Source files
------------

// File: rtl/decimator.sv
// Decimating FIR filter. Each accepted sample goes into a TAPS-deep circular
// history. Every DECIM-th accepted sample triggers a TAPS-cycle
// multiply-accumulate over that history. The result is shifted, saturated and
// registered onto sample_out.
//
// Input handshake: sample_in_valid is a single-cycle strobe with no
// backpressure. A sample that arrives outside IDLE is parked in a one-entry
// holding register and committed in the first IDLE cycle after SAT. A sample
// that arrives while the holding register is occupied is dropped, and overrun
// pulses in the following cycle.
module decimator #(
   parameter int    TAPS       = 64,
   parameter int    DECIM      = 16,
   parameter string COEFF_FILE = "decim_coeffs.mem"
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] sample_in,
   input  logic               sample_in_valid,
   output logic signed [15:0] sample_out,
   output logic               sample_out_valid,
   output logic               overrun
);

   localparam int AW = $clog2(TAPS);
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int CW = $clog2(TAPS + 3);

   typedef enum logic [1:0] {IDLE, PRIME, MAC, SAT} state_t;

   state_t             state, state_nxt;
   logic signed [17:0] coeff_rom [TAPS];
   logic signed [15:0] hist [TAPS];

   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_base;
   logic [AW-1:0]      rd_k;
   logic [AW-1:0]      rd_addr;
   logic [PW-1:0]      phase;
   logic [AW:0]        fill;
   logic [CW-1:0]      cnt;
   logic               hold_valid;
   logic signed [15:0] hold_data;

   logic               commit_hold, accept_new, wr_en, trigger, drop, latch_hold;
   logic signed [15:0] wr_data;

   logic signed [17:0] coeff_q;
   logic signed [15:0] samp_q;
   logic signed [33:0] prod_q;
   logic signed [47:0] acc;
   logic signed [47:0] acc_shr;
   logic signed [15:0] sat_val;

   // Decide whether this cycle writes the history, parks a sample or drops one
   always_comb begin
      commit_hold = (state == IDLE) && hold_valid;
      accept_new  = (state == IDLE) && !hold_valid && sample_in_valid;
      wr_en       = commit_hold || accept_new;
      wr_data     = commit_hold ? hold_data : sample_in;
      trigger     = wr_en && (phase == PW'(DECIM - 1));
      drop        = sample_in_valid && hold_valid;
      latch_hold  = sample_in_valid && !hold_valid && (state != IDLE);
      rd_k        = cnt[AW-1:0];
      rd_addr     = rd_base - rd_k;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: PRIME covers the two-cycle read pipeline, MAC runs TAPS products
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (trigger) state_nxt = PRIME;
         PRIME:   if (cnt == CW'(1)) state_nxt = MAC;
         MAC:     if (cnt == CW'(TAPS + 1)) state_nxt = SAT;
         SAT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Cycle counter through PRIME and MAC; also the tap index issued to the read pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cnt <= '0;
      else if (state == IDLE) cnt <= '0;
      else                    cnt <= cnt + CW'(1);
   end

   // Write pointer, phase, fill level and the pointer snapshot taken at the trigger
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         phase   <= '0;
         fill    <= '0;
         rd_base <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + AW'(1);
         phase  <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
         if (fill != (AW+1)'(TAPS)) fill <= fill + (AW+1)'(1);
         if (trigger) rd_base <= wr_ptr;
      end
   end

   // History RAM write; contents survive reset and are masked by fill instead
   always_ff @(posedge clk) begin
      if (wr_en) hist[wr_ptr] <= wr_data;
   end

   // Read and multiply pipeline: ROM/RAM read stage, then product stage
   always_ff @(posedge clk) begin
      coeff_q <= coeff_rom[rd_k];
      samp_q  <= ({1'b0, rd_k} < fill) ? hist[rd_addr] : '0;
      prod_q  <= coeff_q * samp_q;
   end

   // Holding register for one sample that arrives while the MAC is busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (latch_hold) begin
         hold_valid <= 1'b1;
         hold_data  <= sample_in;
      end else if (commit_hold) begin
         hold_valid <= 1'b0;
      end
   end

   // Full-precision accumulator, cleared when a new computation starts
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                acc <= '0;
      else if (trigger)       acc <= '0;
      else if (state == MAC)  acc <= acc + {{14{prod_q[33]}}, prod_q};
   end

   // Drop the Q1.17 fraction (floor) and clamp to the 16-bit range
   always_comb begin
      acc_shr = acc >>> 17;
      if (acc_shr > 48'sd32767)       sat_val = 16'sh7FFF;
      else if (acc_shr < -48'sd32768) sat_val = 16'sh8000;
      else                            sat_val = acc_shr[15:0];
   end

   // Output registers: update on SAT, overrun pulse follows the dropped strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         sample_out_valid <= (state == SAT);
         overrun          <= drop;
         if (state == SAT) sample_out <= sat_val;
      end
   end

endmodule

// File: tb/tb_decimator.sv
// Bench for decimator: directed DC, impulse and saturation runs, input spacings
// that make the holding register fill or overflow, randomized traffic, and a
// reset during MAC. Expected outputs come from a sample-history reference model.
module tb_decimator;

   localparam int TAPS  = 64;
   localparam int DECIM = 16;
   localparam int W     = 16;
   localparam int LAT   = TAPS + 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] sample_in = '0;
   logic               sample_in_valid = 1'b0;
   logic signed [15:0] sample_out;
   logic               sample_out_valid;
   logic               overrun;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   // scoreboard: expected output values and cycles, expected overrun cycles
   logic [W-1:0] exp_q[$];
   int           exp_t_q[$];
   int           ovr_q[$];
   logic [W-1:0] got_q[$];
   logic [W-1:0] last_out;

   // reference model state
   int coef [TAPS];
   int hist_q[$];
   int m_cnt;
   int m_trig;
   bit m_trig_valid;
   bit m_held;
   int m_held_d;
   int m_commit_cyc;

   decimator #(.TAPS(TAPS), .DECIM(DECIM), .COEFF_FILE("")) dut (
      .clk              (clk),
      .rst              (rst),
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .overrun          (overrun)
   );

   // clock and cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic check_got(input string tag, input int idx, input logic [31:0] exp);
      check(tag, (idx < got_q.size()) ? {16'd0, got_q[idx]} : 32'hFFFF_FFFF, exp);
   endtask

   function automatic int rand_sample();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_out();
      longint acc = 0;
      longint r;
      int     n = hist_q.size();
      for (int k = 0; k < TAPS; k++)
         if (k < n) acc += longint'(coef[k]) * longint'(hist_q[n-1-k]);
      r = acc >>> 17;
      if (r > 32767)  return 16'h7FFF;
      if (r < -32768) return 16'h8000;
      return W'(r);
   endfunction

   function automatic bit model_busy(input int c);
      return m_trig_valid && (c > m_trig) && (c <= m_trig + TAPS + 3);
   endfunction

   task automatic model_accept(input int d, input int c);
      hist_q.push_back(d);
      if (hist_q.size() > TAPS) void'(hist_q.pop_front());
      m_cnt++;
      if (m_cnt % DECIM == 0) begin
         exp_q.push_back(model_out());
         exp_t_q.push_back(c + LAT);
         m_trig       = c;
         m_trig_valid = 1'b1;
      end
   endtask

   task automatic model_cycle(input bit v, input int d);
      int c = cyc;
      bit held_at_start = m_held;
      if (m_held && c == m_commit_cyc) begin
         model_accept(m_held_d, c);
         m_held = 1'b0;
      end
      if (v) begin
         if (held_at_start) ovr_q.push_back(c + 1);
         else if (model_busy(c)) begin
            m_held       = 1'b1;
            m_held_d     = d;
            m_commit_cyc = m_trig + TAPS + 4;
         end else model_accept(d, c);
      end
   endtask

   task automatic model_reset();
      hist_q.delete();
      exp_q.delete();
      exp_t_q.delete();
      ovr_q.delete();
      got_q.delete();
      m_cnt        = 0;
      m_trig       = 0;
      m_trig_valid = 1'b0;
      m_held       = 1'b0;
      last_out     = '0;
   endtask

   // ---------------- monitor ----------------
   task automatic monitor();
      logic [W-1:0] e;
      int           t;
      bit           exp_ovr;
      if (exp_t_q.size() > 0 && cyc > exp_t_q[0]) begin
         t = exp_t_q.pop_front();
         e = exp_q.pop_front();
         check("out_time_missed", cyc, t);
      end
      if (sample_out_valid) begin
         got_q.push_back(sample_out);
         if (exp_q.size() == 0) check("out_spurious", {31'd0, sample_out_valid}, 0);
         else begin
            e = exp_q.pop_front();
            t = exp_t_q.pop_front();
            check("out_value", {16'd0, sample_out}, {16'd0, e});
            check("out_time", cyc, t);
            last_out = e;
         end
      end else check("out_hold", {16'd0, sample_out}, {16'd0, last_out});
      while (ovr_q.size() > 0 && ovr_q[0] < cyc) void'(ovr_q.pop_front());
      exp_ovr = (ovr_q.size() > 0 && ovr_q[0] == cyc);
      if (exp_ovr) void'(ovr_q.pop_front());
      check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input bit v, input int d);
      monitor();
      sample_in_valid = v;
      sample_in       = v ? 16'(d) : 16'($urandom);
      model_cycle(v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int d, input int gap);
      tick(1'b1, d);
      repeat (gap - 1) tick(1'b0, 0);
   endtask

   task automatic drain();
      repeat (LAT + 10) tick(1'b0, 0);
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      sample_in_valid = 1'b0;
      sample_in       = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic load_coeffs(input int mode);
      for (int k = 0; k < TAPS; k++) begin
         case (mode)
            0:       coef[k] = 2048;
            1:       coef[k] = k * 256;
            2:       coef[k] = 131071;
            default: coef[k] = int'($urandom_range(0, 262143)) - 131072;
         endcase
         dut.coeff_rom[k] = 18'(coef[k]);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      load_coeffs(0);
      do_reset();
      check("rst_out", {16'd0, sample_out}, 0);
      check("rst_valid", {31'd0, sample_out_valid}, 0);
      check("rst_ovr", {31'd0, overrun}, 0);

      // DC: 1000 through a 1/64 averager
      repeat (80) feed(1000, 142);
      drain();
      check_got("dc_first", 0, 250);
      check_got("dc_full", 3, 1000);
      check_got("dc_steady", 4, 1000);

      // impulse on a trigger sample against a ramp of coefficients
      load_coeffs(1);
      do_reset();
      repeat (15) feed(0, 142);
      feed(16384, 142);
      repeat (48) feed(0, 142);
      drain();
      check_got("imp_k0", 0, 0);
      check_got("imp_k16", 1, 512);
      check_got("imp_k32", 2, 1024);
      check_got("imp_k48", 3, 1536);

      // saturation both ways
      load_coeffs(2);
      do_reset();
      repeat (64) feed(32767, 80);
      drain();
      check_got("sat_pos", 3, 16'h7FFF);
      do_reset();
      repeat (64) feed(-32768, 80);
      drain();
      check_got("sat_neg", 3, 16'h8000);

      // spacing 40: one sample parked per computation, no overrun
      load_coeffs(3);
      do_reset();
      repeat (48) feed(rand_sample(), 40);
      drain();

      // spacing 20: holding register overflows
      do_reset();
      repeat (48) feed(rand_sample(), 20);
      drain();

      // randomized spacing and data
      do_reset();
      repeat (120) feed(rand_sample(), int'($urandom_range(5, 150)));
      drain();

      // reset 30 cycles after a trigger, in the middle of MAC
      do_reset();
      repeat (31) feed(rand_sample(), 80);
      tick(1'b1, rand_sample());
      repeat (29) tick(1'b0, 0);
      rst = 1'b1;
      #1;
      check("rst_mid_out", {16'd0, sample_out}, 0);
      check("rst_mid_valid", {31'd0, sample_out_valid}, 0);
      check("rst_mid_ovr", {31'd0, overrun}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (40) feed(rand_sample(), 70);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
